// File: rtl/prbs_gen.sv
// Serial test-pattern source for the TX FFE: PRBS7/15/23/31, all-zero, clock and a
// custom repeating word, with single-bit error injection and a saturating bit counter.
module prbs_gen #(
  parameter int PAT_WIDTH = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2:0]           mode,
  input  logic [30:0]          seed,
  input  logic                 load_seed,
  input  logic [PAT_WIDTH-1:0] pattern,
  input  logic                 inj_req,
  output logic                 inj_ack,
  output logic                 out,
  output logic                 valid,
  output logic [CNT_WIDTH-1:0] bit_count
);

  localparam int IW = (PAT_WIDTH > 1) ? $clog2(PAT_WIDTH) : 1;

  localparam logic [2:0] M_PRBS7  = 3'd0;
  localparam logic [2:0] M_PRBS15 = 3'd1;
  localparam logic [2:0] M_PRBS23 = 3'd2;
  localparam logic [2:0] M_PRBS31 = 3'd3;
  localparam logic [2:0] M_ZERO   = 3'd4;
  localparam logic [2:0] M_CLK    = 3'd5;
  localparam logic [2:0] M_CUST   = 3'd6;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [IW-1:0] idx_wrap(input logic [IW-1:0] v);
    return (v == IW'(PAT_WIDTH - 1)) ? '0 : v + IW'(1);
  endfunction

  logic [30:0]   s_p0;
  logic [IW-1:0] idx_p0;
  logic          phase_p0;
  logic [2:0]    mode_last_p0;
  logic          pend_p0;
  logic          inj_req_d_p0;

  logic [2:0]    mode_n;
  logic          adv;
  logic          mode_chg;
  logic [IW-1:0] idx_cur;
  logic          phase_cur;
  logic          lock;
  logic [30:0]   s_use;
  logic          nb;
  logic          bit_nxt;
  logic [30:0]   s_nxt;
  logic          rise;
  logic          inject;

  always_comb begin
    mode_n    = (mode == 3'd7) ? M_ZERO : mode;
    adv       = en & ~load_seed & ~rst;
    mode_chg  = (mode_n != mode_last_p0);
    idx_cur   = mode_chg ? '0 : idx_p0;
    phase_cur = mode_chg ? 1'b1 : phase_p0;

    // A zero state in the active order would lock up the LFSR; restart from all-ones.
    lock = 1'b0;
    case (mode_n)
      M_PRBS7:  lock = ~|s_p0[6:0];
      M_PRBS15: lock = ~|s_p0[14:0];
      M_PRBS23: lock = ~|s_p0[22:0];
      M_PRBS31: lock = ~|s_p0[30:0];
      default:  lock = 1'b0;
    endcase
    s_use = lock ? '1 : s_p0;

    nb = 1'b0;
    case (mode_n)
      M_PRBS7:  nb = s_use[6]  ^ s_use[5];
      M_PRBS15: nb = s_use[14] ^ s_use[13];
      M_PRBS23: nb = s_use[22] ^ s_use[17];
      M_PRBS31: nb = s_use[30] ^ s_use[27];
      default:  nb = 1'b0;
    endcase

    s_nxt   = s_p0;
    bit_nxt = 1'b0;
    case (mode_n)
      M_PRBS7, M_PRBS15, M_PRBS23, M_PRBS31: begin
        s_nxt   = {s_use[29:0], nb};
        bit_nxt = nb;
      end
      M_CLK:   bit_nxt = phase_cur;
      M_CUST:  bit_nxt = pattern[idx_cur];
      default: bit_nxt = 1'b0;
    endcase

    rise   = inj_req & ~inj_req_d_p0;
    inject = adv & (pend_p0 | rise);
  end

  // Output register stage: one bit per advance, error injection applied on the way out.
  always_ff @(posedge clk) begin
    if (rst) begin
      out          <= 1'b0;
      valid        <= 1'b0;
      inj_ack      <= 1'b0;
      bit_count    <= '0;
      s_p0         <= '1;
      idx_p0       <= '0;
      phase_p0     <= 1'b1;
      mode_last_p0 <= M_PRBS7;
      pend_p0      <= 1'b0;
      inj_req_d_p0 <= 1'b0;
    end else begin
      inj_req_d_p0 <= inj_req;
      inj_ack      <= inject;
      if (inject)
        pend_p0 <= 1'b0;
      else if (rise)
        pend_p0 <= 1'b1;

      if (load_seed) begin
        s_p0 <= seed;
      end else if (en) begin
        out          <= bit_nxt ^ inject;
        valid        <= 1'b1;
        bit_count    <= sat_inc(bit_count);
        s_p0         <= s_nxt;
        idx_p0       <= (mode_n == M_CUST) ? idx_wrap(idx_cur) : idx_cur;
        phase_p0     <= (mode_n == M_CLK) ? ~phase_cur : phase_cur;
        mode_last_p0 <= mode_n;
      end
    end
  end

endmodule

// File: doc/prbs_gen.md
PRBS_GEN -- requirements
Module: prbs_gen

Interface
REQ-001 The block SHALL have parameter PAT_WIDTH, default 32: length in bits of the custom repeating pattern.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 32: width of the emitted-bit counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  advance request; one bit is produced per cycle in which it is high.
REQ-006 mode  input  3  pattern select: 0 PRBS7, 1 PRBS15, 2 PRBS23, 3 PRBS31, 4 all-zero, 5 clock, 6 custom; 7 is treated as 4.
REQ-007 seed  input  31  LFSR seed; bits above the active order are ignored.
REQ-008 load_seed  input  1  loads seed into the LFSR.
REQ-009 pattern  input  PAT_WIDTH  custom pattern, emitted LSB first.
REQ-010 inj_req  input  1  single-bit error-injection request.
REQ-011 inj_ack  output  1  one-cycle acknowledge of an injection.
REQ-012 out  output  1  registered serial bit; drives the 1-bit data input of the TX FFE.
REQ-013 valid  output  1  high once at least one bit has been produced since reset.
REQ-014 bit_count  output  CNT_WIDTH  number of bits produced since reset, saturating.

Function
REQ-015 The block SHALL treat a cycle with en=1, load_seed=0 and rst=0 as an advance; only an advance SHALL change out, bit_count or the pattern state.
REQ-016 Latency SHALL be one cycle: the bit for an advance in cycle k SHALL appear on out in cycle k+1, and out SHALL hold between advances.
REQ-017 The PRBS modes SHALL use a 31-bit state s, new bit nb = s[n-1]^s[t-1] and update s <= {s[29:0],nb}, with out <= nb and (n,t) = (7,6), (15,14), (23,18), (31,28) for modes 0-3.
REQ-018 If the low n bits of s are all zero at an advance in a PRBS mode, the block SHALL set s to all-ones and emit nb computed from the all-ones state (lock-up recovery).
REQ-019 Mode 4 SHALL emit 0 on every advance.
REQ-020 Mode 5 SHALL emit 1,0,1,0,... starting with 1 on the first advance after entering the mode.
REQ-021 Mode 6 SHALL emit pattern[idx] with idx 0..PAT_WIDTH-1 incrementing per advance and wrapping to 0 after PAT_WIDTH-1; pattern SHALL be sampled live at each advance.
REQ-022 A change of mode SHALL reset idx to 0 and the clock-phase to 1 at the next advance, and SHALL leave s unchanged.
REQ-023 load_seed=1 SHALL load s <= seed with no advance that cycle, even if en=1; an all-zero seed SHALL be stored as given and recovered by REQ-018.
REQ-024 The block SHALL arm an injection on a rising edge of inj_req (low in the previous cycle, high now); at most one injection SHALL be pending.
REQ-025 At the first advance at or after arming, the block SHALL invert the emitted bit, pulse inj_ack high for exactly the cycle in which the inverted bit is on out, and clear the pending flag.
REQ-026 Injection SHALL NOT alter s, idx or the clock-phase.
REQ-027 A request that stays high SHALL produce only one injection; a second injection SHALL require inj_req to return low for at least one cycle.
REQ-028 A pending injection SHALL survive load_seed cycles, mode changes and en=0 cycles.
REQ-029 bit_count SHALL increment by 1 per advance and hold at 2^CNT_WIDTH-1.
REQ-030 valid SHALL rise in the cycle after the first advance and stay high until reset.

Reset
REQ-031 While rst=1, the block SHALL set out=0, valid=0, inj_ack=0 and bit_count=0, set s to all-ones (31'h7FFF_FFFF), set idx=0 and clock-phase=1, and clear the pending injection.
REQ-032 rst SHALL override en, load_seed and inj_req in the same cycle, including mid-pattern and with an injection pending.
REQ-033 The first advance after rst deasserts SHALL behave as the first advance after power-up.

Verification
REQ-034 Release reset, mode=0, en=1 continuous -> out sequence begins 0,0,0,0,0,0,1; bit n+127 equals bit n for n=1..200; bit_count=127 after 127 advances.
REQ-035 mode=6, pattern=32'hA5A5_0001, en=1 for 40 cycles -> out = 1, then 15 zeros, then bits of A5A5 LSB first (1,0,1,0,0,1,0,1,...); bit 33 equals bit 1 (wrap).
REQ-036 mode=3, load_seed=1 with seed=0 and en=1 in the same cycle -> out unchanged that cycle; next advance emits the first bit from the all-ones state (0) with no lock-up.
REQ-037 mode=1, inj_req held high for 10 cycles during en=1 -> exactly one inj_ack pulse; that bit is inverted versus a golden PRBS15; all later bits match golden.
REQ-038 mode=5, toggle en 1,0,1,1 -> out 1 (held), 0, 1; then rst mid-stream -> out=0, valid=0, bit_count=0 next cycle.
